// File: rtl/acc_burst_4bit.sv
// acc_burst_4bit: burst accumulator fed by a 4-bit ripple-carry adder.
// It accepts BURST beats of (sum, carry-out) over a valid/ready handshake.
// It accumulates the beats into a WIDTH-bit result and counts overflow events.
// It then presents the result on a second valid/ready handshake.
//
// Optional feature macro: ACC_SATURATE_EN
//   defined   -> the accumulator clamps at 2^WIDTH-1 after any overflow event
//   undefined -> the accumulator wraps modulo 2^WIDTH
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        begins a burst (sampled only in IDLE)
//   in_valid     in_data/in_carry valid
//   in_data      adder sum (WIDTH bits)
//   in_carry     adder carry-out, weight 2^WIDTH
//   in_ready     block accepts a beat (ACCUM only)
//   out_valid    result available (DONE only)
//   out_ready    downstream accepts result
//   out_sum      accumulated result (WIDTH bits)
//   out_ovf_cnt  overflow events in the burst, saturating at 15
//   busy         state is not IDLE
module acc_burst_4bit #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_carry,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [3:0]       out_ovf_cnt,
  output logic             busy
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned OVF_W = 4;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);
  localparam logic [OVF_W-1:0] OVF_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [OVF_W-1:0] r_ovf_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic             w_accept;
  logic [WIDTH:0]   w_sum;
  logic [1:0]       w_ovf_inc;
  logic [OVF_W:0]   w_ovf_sum;
  logic [OVF_W-1:0] w_ovf_next;
  logic [WIDTH-1:0] w_acc_next;

  // r_in_ready is high exactly in ACCUM, so it doubles as the accept qualifier
  assign w_accept = in_valid & r_in_ready;

  // One extra bit catches the wrap of acc + in_data
  assign w_sum     = {1'b0, r_acc} + {1'b0, in_data};
  // Per-beat overflow events: accumulator wrap plus the adder's own carry-out
  assign w_ovf_inc = 2'(w_sum[WIDTH]) + 2'(in_carry);
  assign w_ovf_sum = {1'b0, r_ovf_cnt} + (OVF_W + 1)'(w_ovf_inc);
  assign w_ovf_next = (w_ovf_sum > {1'b0, OVF_MAX}) ? OVF_MAX : w_ovf_sum[OVF_W-1:0];

  // Next accumulator value: clamp on any overflow event, or plain wrap
  always_comb begin
    w_acc_next = w_sum[WIDTH-1:0];
`ifdef ACC_SATURATE_EN
    if (w_ovf_inc != 2'd0) begin
      w_acc_next = '1;
    end
`endif
  end

  // Burst sequencing FSM with registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_beat_cnt  <= '0;
      r_ovf_cnt   <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc      <= '0;
            r_beat_cnt <= '0;
            r_ovf_cnt  <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_acc     <= w_acc_next;
            r_ovf_cnt <= w_ovf_next;
            if (r_beat_cnt == LAST_BEAT) begin
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  // The accumulator register is the result; it holds through DONE and IDLE
  assign out_sum     = r_acc;
  assign out_ovf_cnt = r_ovf_cnt;
  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign busy        = r_busy;

endmodule

// File: tb/tb_acc_burst_4bit.sv
// Directed testbench for acc_burst_4bit (WIDTH=4, BURST=4).
module tb_acc_burst_4bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_carry;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_sum;
  logic [3:0] out_ovf_cnt;
  logic       busy;

  int checks = 0;
  int errors = 0;

  acc_burst_4bit #(.WIDTH(4), .BURST(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_carry(in_carry),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf_cnt(out_ovf_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a burst and feed four beats, with 'gap' idle cycles before each beat
  task automatic run_burst(input logic [3:0] d0, input logic c0,
                           input logic [3:0] d1, input logic c1,
                           input logic [3:0] d2, input logic c2,
                           input logic [3:0] d3, input logic c3,
                           input int gap);
    logic [3:0] d [4];
    logic       c [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        in_data  = 4'hF;
        in_carry = 1'b1;
        tick();
      end
      in_valid = 1'b1;
      in_data  = d[i];
      in_carry = c[i];
      tick();
    end
    in_valid = 1'b0;
    in_data  = 4'd0;
    in_carry = 1'b0;
  endtask

  // Complete the result handshake
  task automatic take_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_idle_in_ready got %b exp 0", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b exp 0", busy); end
    checks++; if (out_sum !== 4'd0) begin errors++; $display("FAIL reset_idle_sum got %0d exp 0", out_sum); end
    checks++; if (out_ovf_cnt !== 4'd0) begin errors++; $display("FAIL reset_idle_ovf got %0d exp 0", out_ovf_cnt); end
    // Reach DONE with a nonzero result, then reset there
    run_burst(4'd7, 1'b1, 4'd7, 1'b0, 4'd1, 1'b0, 4'd1, 1'b0, 0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL reset_pre_done got %b exp 1", out_valid); end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_done_out_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_done_busy got %b exp 0", busy); end
    checks++; if (out_sum !== 4'd0) begin errors++; $display("FAIL reset_done_sum got %0d exp 0", out_sum); end
    checks++; if (out_ovf_cnt !== 4'd0) begin errors++; $display("FAIL reset_done_ovf got %0d exp 0", out_ovf_cnt); end
    // rst and start together: reset wins
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_with_start_busy got %b exp 0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_with_start_in_ready got %b exp 0", in_ready); end
  endtask

  task automatic test_basic();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready_after_start got %b exp 1", in_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_after_start got %b exp 1", busy); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_out_valid beat %0d got %b exp 0", i, out_valid); end
      in_valid = 1'b1;
      in_data  = 4'(i);
      in_carry = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got %b exp 1", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_done got %b exp 0", in_ready); end
    checks++; if (out_sum !== 4'd10) begin errors++; $display("FAIL basic_sum got %0d exp 10", out_sum); end
    checks++; if (out_ovf_cnt !== 4'd0) begin errors++; $display("FAIL basic_ovf got %0d exp 0", out_ovf_cnt); end
    take_result();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_out_valid_after_hs got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after_hs got %b exp 0", busy); end
    checks++; if (out_sum !== 4'd10) begin errors++; $display("FAIL basic_sum_held_idle got %0d exp 10", out_sum); end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_sum;
`ifdef ACC_SATURATE_EN
    exp_sum = 4'd15;
`else
    exp_sum = 4'd2;
`endif
    run_burst(4'd9, 1'b0, 4'd9, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 0);
    checks++; if (out_sum !== exp_sum) begin errors++; $display("FAIL wrap_sum got %0d exp %0d", out_sum, exp_sum); end
    checks++; if (out_ovf_cnt !== 4'd1) begin errors++; $display("FAIL wrap_ovf got %0d exp 1", out_ovf_cnt); end
    take_result();
  endtask

  task automatic test_carry();
    logic [3:0] exp_sum;
`ifdef ACC_SATURATE_EN
    exp_sum = 4'd15;
`else
    exp_sum = 4'd14;
`endif
    run_burst(4'd15, 1'b1, 4'd15, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 0);
    checks++; if (out_sum !== exp_sum) begin errors++; $display("FAIL carry_sum got %0d exp %0d", out_sum, exp_sum); end
    checks++; if (out_ovf_cnt !== 4'd3) begin errors++; $display("FAIL carry_ovf got %0d exp 3", out_ovf_cnt); end
    take_result();
  endtask

  task automatic test_ovf_saturate();
    // 2 events per beat for three bursts' worth is not possible in one burst of 4;
    // four beats of 15/c1 give 1+2+2+2 = 7 events
    logic [3:0] exp_sum;
`ifdef ACC_SATURATE_EN
    exp_sum = 4'd15;
`else
    exp_sum = 4'd12;
`endif
    run_burst(4'd15, 1'b1, 4'd15, 1'b1, 4'd15, 1'b1, 4'd15, 1'b1, 0);
    checks++; if (out_sum !== exp_sum) begin errors++; $display("FAIL ovf4_sum got %0d exp %0d", out_sum, exp_sum); end
    checks++; if (out_ovf_cnt !== 4'd7) begin errors++; $display("FAIL ovf4_cnt got %0d exp 7", out_ovf_cnt); end
    take_result();
  endtask

  task automatic test_backpressure();
    run_burst(4'd1, 1'b0, 4'd2, 1'b0, 4'd3, 1'b0, 4'd4, 1'b0, 0);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = ~i[0];
      start    = i[0];
      in_data  = 4'd7;
      in_carry = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid cyc %0d got %b exp 1", i, out_valid); end
      checks++; if (out_sum !== 4'd10) begin errors++; $display("FAIL bp_sum cyc %0d got %0d exp 10", i, out_sum); end
      checks++; if (out_ovf_cnt !== 4'd0) begin errors++; $display("FAIL bp_ovf cyc %0d got %0d exp 0", i, out_ovf_cnt); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b exp 0", i, in_ready); end
    end
    in_valid = 1'b0; start = 1'b0; in_data = 4'd0; in_carry = 1'b0;
    take_result();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_release_busy got %b exp 0", busy); end
    checks++; if (out_sum !== 4'd10) begin errors++; $display("FAIL bp_release_sum got %0d exp 10", out_sum); end
  endtask

  task automatic test_reset_mid_burst_gaps();
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 4'd3; in_carry = 1'b1;
    tick();
    tick();
    in_valid = 1'b0; in_carry = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
    checks++; if (out_sum !== 4'd0) begin errors++; $display("FAIL midrst_sum got %0d exp 0", out_sum); end
    checks++; if (out_ovf_cnt !== 4'd0) begin errors++; $display("FAIL midrst_ovf got %0d exp 0", out_ovf_cnt); end
    run_burst(4'd1, 1'b0, 4'd1, 1'b0, 4'd1, 1'b0, 4'd1, 1'b0, 2);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gaps_out_valid got %b exp 1", out_valid); end
    checks++; if (out_sum !== 4'd4) begin errors++; $display("FAIL gaps_sum got %0d exp 4", out_sum); end
    checks++; if (out_ovf_cnt !== 4'd0) begin errors++; $display("FAIL gaps_ovf got %0d exp 0", out_ovf_cnt); end
    take_result();
  endtask

  task automatic test_back_to_back();
    run_burst(4'd2, 1'b0, 4'd2, 1'b0, 4'd2, 1'b0, 4'd2, 1'b0, 0);
    checks++; if (out_sum !== 4'd8) begin errors++; $display("FAIL b2b_first_sum got %0d exp 8", out_sum); end
    take_result();
    // Earliest new start is sampled in the cycle right after the handshake
    run_burst(4'd5, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b0, 0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_valid got %b exp 1", out_valid); end
    checks++; if (out_sum !== 4'd6) begin errors++; $display("FAIL b2b_second_sum got %0d exp 6", out_sum); end
    take_result();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 4'd0;
    in_carry = 1'b0; out_ready = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_wrap();
    test_carry();
    test_ovf_saturate();
    test_backpressure();
    test_reset_mid_burst_gaps();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
